// File: rtl/imem_loader.sv
// Byte-stream program loader: assembles little-endian 32-bit words and writes them to instruction memory.
// Optional trailing checksum word is enabled with IMEM_LOAD_CHECKSUM_EN.
module imem_loader #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned MEM_SIZE   = 64,
    parameter int unsigned BASE_ADDR  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] word_cnt,
    input  logic                  s_valid,
    input  logic [7:0]            s_data,
    output logic                  s_ready,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] waddr,
    output logic [31:0]           wdata,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);

`ifdef IMEM_LOAD_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, DONE, CHECK} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;
`endif

    localparam int unsigned EXT_W = ADDR_WIDTH + 3;

    state_t                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] rem_q;
    logic [1:0]            lane_q;
    logic [23:0]           word_q;
    logic [23:0]           word_d;
    logic                  s_ready_q;
    logic                  we_q;
    logic [ADDR_WIDTH-1:0] waddr_q;
    logic [31:0]           wdata_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  err_q;
`ifdef IMEM_LOAD_CHECKSUM_EN
    logic [31:0]           csum_q;
`endif

    logic [EXT_W-1:0] end_addr;
    logic             out_of_range;
    logic             hs;

    // Extended width keeps BASE_ADDR + 4*word_cnt from wrapping.
    assign end_addr     = EXT_W'(BASE_ADDR) + (EXT_W'(word_cnt) << 2);
    assign out_of_range = end_addr > EXT_W'(MEM_SIZE);
    assign hs           = s_valid && s_ready_q;

    // Lanes 0..2 are buffered; lane 3 is taken straight from s_data.
    always_comb begin
        word_d = word_q;
        case (lane_q)
            2'd0:    word_d[7:0]   = s_data;
            2'd1:    word_d[15:8]  = s_data;
            2'd2:    word_d[23:16] = s_data;
            default: word_d        = word_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rem_q     <= '0;
            lane_q    <= '0;
            word_q    <= '0;
            s_ready_q <= 1'b0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
            csum_q    <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        err_q <= 1'b0;
                        if (word_cnt == '0) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else if (out_of_range) begin
                            err_q   <= 1'b1;
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else begin
                            addr_q    <= ADDR_WIDTH'(BASE_ADDR);
                            rem_q     <= word_cnt;
                            lane_q    <= '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
                            csum_q    <= '0;
`endif
                            busy_q    <= 1'b1;
                            s_ready_q <= 1'b1;
                            state_q   <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (hs) begin
                        lane_q <= lane_q + 2'd1;
                        if (lane_q == 2'd3) begin
                            wdata_q   <= {s_data, word_q};
                            waddr_q   <= addr_q;
                            we_q      <= 1'b1;
                            s_ready_q <= 1'b0;
                            state_q   <= WRITE;
                        end else begin
                            word_q <= word_d;
                        end
                    end
                end
                WRITE: begin
                    we_q   <= 1'b0;
                    addr_q <= addr_q + ADDR_WIDTH'(4);
                    rem_q  <= rem_q - ADDR_WIDTH'(1);
                    lane_q <= '0;
`ifdef IMEM_LOAD_CHECKSUM_EN
                    csum_q <= csum_q ^ wdata_q;
`endif
                    if (rem_q == ADDR_WIDTH'(1)) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
                        s_ready_q <= 1'b1;
                        state_q   <= CHECK;
`else
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
`endif
                    end else begin
                        s_ready_q <= 1'b1;
                        state_q   <= LOAD;
                    end
                end
`ifdef IMEM_LOAD_CHECKSUM_EN
                CHECK: begin
                    if (hs) begin
                        lane_q <= lane_q + 2'd1;
                        if (lane_q == 2'd3) begin
                            if ({s_data, word_q} != csum_q) begin
                                err_q <= 1'b1;
                            end
                            s_ready_q <= 1'b0;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            state_q   <= DONE;
                        end else begin
                            word_q <= word_d;
                        end
                    end
                end
`endif
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign s_ready = s_ready_q;
    assign we      = we_q;
    assign waddr   = waddr_q;
    assign wdata   = wdata_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign err     = err_q;

endmodule
